// File: rtl/cnn_pkg.sv
// Shared constants and the FSM state type for the OFM2 write arbiter.
//   DEF_NUM_REQ       default number of filter streams sharing the port
//   DEF_WORDS_PER_REQ default 32-bit words in each requester's region
//   OFM_DEPTH         total words in OFM2
//   PIX_W             pixel width in bits
//   state_e           IDLE / RUN / DONE layer-pass states
package cnn_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_WORDS_PER_REQ = 32;
    localparam int OFM_DEPTH         = 128;
    localparam int PIX_W             = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req         in   N      request vector
//   ptr         in   IDX_W  highest-priority index this cycle
//   grant       out  N      one-hot grant (zero when nothing requests)
//   grant_idx   out  IDX_W  index of the granted requester
//   grant_valid out  1      some requester was granted
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int k;

    // Walk the requesters starting at ptr and wrapping; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!grant_valid && req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
                grant[k]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofm_write_arbiter.sv
// Shares one OFM2 word-write port among NUM_REQ filter output streams.
// Each stream's 8-bit pixels are packed four to a word (first pixel in
// [31:24]); finished words are written round-robin, one per cycle, into
// the stream's own region at base r*WORDS_PER_REQ.
//   clk, rst_n   clock and synchronous active-low reset
//   start        pulse: clear counters and begin a pass (ignored in RUN)
//   in_valid     per-requester pixel valid
//   in_data      per-requester pixel, requester r on [8r+7:8r]
//   in_ready     per-requester accept
//   mem_wr       registered write strobe
//   mem_addr     registered word address
//   mem_wr_data  registered packed word
//   busy         pass in progress
//   done         every region written; holds until next start
//   fsm_state    current FSM state, for observation
module ofm_write_arbiter
    import cnn_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int WORDS_PER_REQ = DEF_WORDS_PER_REQ,
    parameter int ADDR_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [8*NUM_REQ-1:0] in_data,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic                 mem_wr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           fsm_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WORDS_PER_REQ + 1);

    state_e             state;
    logic [1:0]         byte_cnt [NUM_REQ];
    logic [CNT_W-1:0]   word_cnt [NUM_REQ];
    logic [31:0]        word_buf [NUM_REQ];
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pending_set;
    logic [NUM_REQ-1:0] take;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               all_full;

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign fsm_state = state;

    // Handshake: a byte moves when in_valid[r] and in_ready[r] are both high
    // at the rising edge. in_ready depends only on registered state, so it
    // never combinationally depends on in_valid.
    always_comb begin
        in_ready    = '0;
        take        = '0;
        pending_set = '0;
        all_full    = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            in_ready[r] = busy & ~pending[r] &
                          (word_cnt[r] < CNT_W'(WORDS_PER_REQ));
            take[r]     = in_valid[r] & in_ready[r];
            // The 4th byte completes the word and blocks the stream until written.
            pending_set[r] = take[r] & (byte_cnt[r] == 2'd3);
            if (word_cnt[r] != CNT_W'(WORDS_PER_REQ)) begin
                all_full = 1'b0;
            end
        end
    end

    assign arb_req = pending & {NUM_REQ{busy}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req         (arb_req),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            pending     <= '0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                byte_cnt[r] <= '0;
                word_cnt[r] <= '0;
                word_buf[r] <= '0;
            end
        end else begin
            mem_wr <= grant_valid;
            if (grant_valid) begin
                mem_addr    <= ADDR_W'(grant_idx) * ADDR_W'(WORDS_PER_REQ)
                               + ADDR_W'(word_cnt[grant_idx]);
                mem_wr_data <= word_buf[grant_idx];
                word_cnt[grant_idx] <= word_cnt[grant_idx] + CNT_W'(1);
                rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0
                                                           : grant_idx + IDX_W'(1);
            end

            // A pending stream has in_ready low, so set and clear never hit
            // the same bit in one cycle.
            pending <= (pending | pending_set) & ~grant;

            for (int r = 0; r < NUM_REQ; r++) begin
                if (take[r]) begin
                    word_buf[r][(3 - int'(byte_cnt[r])) * 8 +: 8] <= in_data[8*r +: 8];
                    byte_cnt[r] <= byte_cnt[r] + 2'd1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    // No handshakes or grants happen outside RUN, so clearing
                    // here cannot collide with the updates above.
                    if (start) begin
                        state   <= RUN;
                        rr_ptr  <= '0;
                        pending <= '0;
                        for (int r = 0; r < NUM_REQ; r++) begin
                            byte_cnt[r] <= '0;
                            word_cnt[r] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (all_full && (pending == '0)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofm_write_arbiter.sv
module tb_ofm_write_arbiter;

    localparam int NR  = 4;
    localparam int WPR = 32;
    localparam int AW  = 32;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NR-1:0]   in_valid = '0;
    logic [8*NR-1:0] in_data = '0;
    logic [NR-1:0]   in_ready;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wr_data;
    logic            busy;
    logic            done;
    logic [1:0]      fsm_state;

    always #5 clk = ~clk;

    ofm_write_arbiter #(
        .NUM_REQ       (NR),
        .WORDS_PER_REQ (WPR),
        .ADDR_W        (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Model: every byte accepted this pass, per stream, plus words written.
    // A stream is "pending" while it has a full group of four accepted bytes
    // that has not yet appeared on the write port.
    logic [7:0]    acc [NR][4*WPR];
    int            n_acc [NR];
    int            written [NR];
    int            m_rr;
    int            m_phase;      // 0 idle, 1 running, 2 finished
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;

    // Observed writes, compared against exp_q in directed tests.
    logic [AW-1:0] wr_log [$];
    logic [31:0]   wr_dlog [$];
    logic [AW-1:0] exp_q [$];
    int            cyc = 0;
    int            last_wr_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pend(input int r);
        return (n_acc[r] / 4) > written[r];
    endfunction

    function automatic logic [31:0] word_of(input int r, input int w);
        return {acc[r][4*w], acc[r][4*w+1], acc[r][4*w+2], acc[r][4*w+3]};
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            n_acc[r]   = 0;
            written[r] = 0;
        end
        m_rr = 0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle(input logic st, input logic [NR-1:0] v, input logic [8*NR-1:0] d);
        logic [NR-1:0] rdy;
        int            g;
        int            k;
        bit            all_full;
        bit            any_pend;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_data  = d;
        rdy      = '0;
        g        = -1;
        all_full = 1;
        any_pend = 0;
        for (int r = 0; r < NR; r++) begin
            rdy[r] = (m_phase == 1) && !pend(r) && (written[r] < WPR);
            if (pend(r)) any_pend = 1;
            if (written[r] < WPR) all_full = 0;
        end
        if (rst_n) check_eq("in_ready", in_ready, rdy);
        if (m_phase == 1) begin
            for (int i = 0; i < NR; i++) begin
                k = (m_rr + i) % NR;
                if (g < 0 && pend(k)) g = k;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_wr) begin
            wr_log.push_back(mem_addr);
            wr_dlog.push_back(mem_wr_data);
            last_wr_cyc = cyc;
        end
        if (!rst_n) begin
            model_clear();
            m_phase = 0;
            m_addr  = '0;
            m_data  = '0;
            check_eq("rst_mem_wr", mem_wr, 0);
            check_eq("rst_addr", mem_addr, 0);
            check_eq("rst_data", mem_wr_data, 0);
            check_eq("rst_ready", in_ready, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_state", fsm_state, 0);
        end else begin
            if (g >= 0) begin
                m_addr = AW'(g * WPR + written[g]);
                m_data = word_of(g, written[g]);
                written[g]++;
                m_rr = (g + 1) % NR;
            end
            check_eq("mem_wr", mem_wr, (g >= 0));
            check_eq("mem_addr", mem_addr, m_addr);
            check_eq("mem_data", mem_wr_data, m_data);
            for (int r = 0; r < NR; r++) begin
                if (v[r] && rdy[r]) begin
                    acc[r][n_acc[r]] = d[8*r +: 8];
                    n_acc[r]++;
                end
            end
            if (m_phase == 1) begin
                if (all_full && !any_pend) m_phase = 2;
            end else if (st) begin
                model_clear();
                m_phase = 1;
            end
            check_eq("busy", busy, (m_phase == 1));
            check_eq("done", done, (m_phase == 2));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b0, '0, '0);
        rst_n = 1'b1;
    endtask

    // Four bytes on a set of streams, one per cycle, same byte on each.
    task automatic send_word(input logic [NR-1:0] mask, input logic [31:0] w);
        logic [8*NR-1:0] d;
        for (int b = 0; b < 4; b++) begin
            d = '0;
            for (int r = 0; r < NR; r++) d[8*r +: 8] = w[31 - 8*b -: 8];
            cycle(1'b0, mask, d);
        end
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check_eq({tag, "_addr"}, wr_log[i], exp_q[i]);
        exp_q.delete();
        wr_log.delete();
        wr_dlog.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen [NR*WPR];
        int guard;
        int done_cyc;
        logic [NR-1:0]   v;
        logic [8*NR-1:0] d;
        bit st;

        model_clear();
        m_phase = 0;
        m_addr  = '0;
        m_data  = '0;

        // 1. single stream
        do_reset();
        do_reset();
        cycle(1'b1, '0, '0);
        send_word(4'b0001, 32'h11223344);
        idle(3);
        exp_q.push_back(0);
        check_eq("t1_data", (wr_dlog.size() > 0) ? wr_dlog[0] : 32'hx, 32'h11223344);
        check_log("t1");

        // 2. contention: all four complete on the same edge
        do_reset();
        cycle(1'b1, '0, '0);
        send_word(4'b1111, 32'hA1B2C3D4);
        idle(6);
        exp_q.push_back(0); exp_q.push_back(32); exp_q.push_back(64); exp_q.push_back(96);
        check_log("t2");

        // 3. fairness: req1 moves the pointer to 2, then req0 and req3 race
        send_word(4'b0010, 32'h01020304);
        idle(3);
        send_word(4'b1001, 32'h55667788);
        idle(4);
        exp_q.push_back(33); exp_q.push_back(97); exp_q.push_back(1);
        check_log("t3");

        // 4. full pass with random valids; stray starts in RUN must be ignored
        do_reset();
        cycle(1'b1, '0, '0);
        guard = 0;
        done_cyc = -1;
        while (m_phase != 2 && guard < 5000) begin
            for (int r = 0; r < NR; r++) v[r] = ($urandom_range(0, 9) < 7);
            d  = $urandom;
            st = ($urandom_range(0, 19) == 0);
            cycle(st, v, d);
            if (done && done_cyc < 0) done_cyc = cyc;
            guard++;
        end
        check_eq("t4_finished", (m_phase == 2), 1);
        check_eq("t4_done_lag", done_cyc - last_wr_cyc, 1);
        check_eq("t4_writes", wr_log.size(), NR*WPR);
        for (int a = 0; a < NR*WPR; a++) seen[a] = 0;
        foreach (wr_log[i]) if (wr_log[i] < NR*WPR) seen[wr_log[i]]++;
        for (int a = 0; a < NR*WPR; a++) check_eq("t4_addr_once", seen[a], 1);
        wr_log.delete();
        wr_dlog.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, '1, $urandom);
        check_eq("t4_no_writes_after", wr_log.size(), 0);

        // 5. restart from DONE
        cycle(1'b1, '0, '0);
        check_eq("t5_done_low", done, 0);
        send_word(4'b0010, 32'hCAFEBABE);
        idle(3);
        exp_q.push_back(32);
        check_eq("t5_data", (wr_dlog.size() > 0) ? wr_dlog[0] : 32'hx, 32'hCAFEBABE);
        check_log("t5");

        // 6. reset mid-word drops the partial word
        cycle(1'b0, 4'b0001, 32'h000000EE);
        cycle(1'b0, 4'b0001, 32'h000000FF);
        do_reset();
        idle(3);
        check_eq("t6_no_write", wr_log.size(), 0);
        cycle(1'b1, '0, '0);
        send_word(4'b0001, 32'hAABBCCDD);
        idle(3);
        exp_q.push_back(0);
        check_eq("t6_data", (wr_dlog.size() > 0) ? wr_dlog[0] : 32'hx, 32'hAABBCCDD);
        check_log("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
